fre_meas_ctrl: RTL

Measurement sequencer for the frequency-meter path of the oscilloscope/VGA design. It takes the comparator `pulse` from the trigger front end and opens a fixed-length gate window. It counts rising edges during the gate, then drives a sequential binary-to-BCD conversion. The six BCD digits it latches feed the on-screen frequency readout.

---
 rtl/fre_meas_ctrl_pkg.sv | 15 +
 rtl/fre_meas_ctrl_if.sv | 29 ++
 rtl/fre_meas_ctrl_bin2bcd_seq.sv | 67 ++++++
 rtl/fre_meas_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fre_meas_ctrl_pkg.sv
// Shared types and constants for the frequency-meter measurement path.
package fre_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    CONV  = 2'd2,
    LATCH = 2'd3
  } fre_state_e;

  localparam int unsigned BCD_W    = 4;
  localparam int unsigned NUM_DIG  = 6;
  localparam int unsigned DISP_MAX = 999_999;

endpackage

// File: rtl/fre_meas_ctrl_if.sv
// Bundle of the measurement controls and the six-digit readout.
interface fre_meas_ctrl_if;
  import fre_pkg::*;

  logic             pulse;
  logic             meas_en;
  logic             gate;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [BCD_W-1:0] fre_num_u;
  logic [BCD_W-1:0] fre_num_d;
  logic [BCD_W-1:0] fre_num_h;
  logic [BCD_W-1:0] fre_num_t;
  logic [BCD_W-1:0] fre_num_m;
  logic [BCD_W-1:0] fre_num_l;

  modport master (
    input  pulse, meas_en,
    output gate, busy, done, ovf,
    output fre_num_u, fre_num_d, fre_num_h, fre_num_t, fre_num_m, fre_num_l
  );

  modport slave (
    output pulse, meas_en,
    input  gate, busy, done, ovf,
    input  fre_num_u, fre_num_d, fre_num_h, fre_num_t, fre_num_m, fre_num_l
  );
endinterface

// File: rtl/fre_meas_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit consumed per cycle.
// The load cycle also consumes the MSB (the add-3 step is a no-op on an
// all-zero BCD register), so conv_done rises CNT_W cycles after start.
// Assumes CNT_W >= 2 and an input value below 10**NUM_DIG.
module bin2bcd_seq
  import fre_pkg::*;
#(
  parameter int unsigned CNT_W = 20
) (
  input  logic                     clk100,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         bin_i,
  output logic [NUM_DIG*BCD_W-1:0] bcd_o,
  output logic                     conv_done
);
  localparam int unsigned BW = NUM_DIG * BCD_W;
  localparam int unsigned IW = $clog2(CNT_W + 1);

  logic [CNT_W-1:0] sh_q;
  logic [BW-1:0]    bcd_q;
  logic [IW-1:0]    idx_q;
  logic             run_q;
  logic             done_q;

  // One double-dabble iteration: correct digits >= 5, then shift in a bit.
  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b, input logic bit_in);
    logic [BW-1:0] a;
    a = b;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (a[i*BCD_W +: BCD_W] >= 4'd5)
        a[i*BCD_W +: BCD_W] = a[i*BCD_W +: BCD_W] + 4'd3;
    end
    return {a[BW-2:0], bit_in};
  endfunction

  // Load on start, then shift one bit per cycle until all CNT_W bits are in.
  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      idx_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        bcd_q <= dabble('0, bin_i[CNT_W-1]);
        sh_q  <= bin_i << 1;
        idx_q <= IW'(1);
        run_q <= 1'b1;
      end else if (run_q) begin
        bcd_q <= dabble(bcd_q, sh_q[CNT_W-1]);
        sh_q  <= sh_q << 1;
        idx_q <= idx_q + 1'b1;
        if (idx_q == IW'(CNT_W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bcd_o     = bcd_q;
  assign conv_done = done_q;

endmodule

// File: rtl/fre_meas_ctrl.sv
// Frequency-meter sequencer: synchronise the input, count its rising edges
// over a fixed gate window, convert the count to BCD and latch the readout.
module fre_meas_ctrl
  import fre_pkg::*;
#(
  parameter int unsigned GATE_CYC  = 100_000_000,
  parameter int unsigned COUNT_MAX = DISP_MAX,
  parameter int unsigned CNT_W     = 20
) (
  input  logic            clk100,
  input  logic            rst,
  fre_meas_ctrl_if.master bus
);
  localparam int unsigned      BW        = NUM_DIG * BCD_W;
  localparam int unsigned      GCW       = $clog2(GATE_CYC + 1);
  localparam logic [GCW-1:0]   GATE_LAST = GCW'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LIM   = CNT_W'(COUNT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(COUNT_MAX + 1);

  fre_state_e       state_q;
  logic [1:0]       sync_q;
  logic             prev_q;
  logic             edge_stb_q;
  logic [GCW-1:0]   gate_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic [CNT_W-1:0] edge_cnt_d;
  logic [CNT_W-1:0] bin_clamped;
  logic             ovf_flag;
  logic             start_q;
  logic             gate_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;
  logic [BW-1:0]    digits_q;
  logic [BW-1:0]    bcd;
  logic             conv_done;

  // Saturated counts are shown as the display limit.
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] v);
    return (v > CNT_LIM) ? CNT_LIM : v;
  endfunction

  // Two-flop synchroniser followed by a registered rising-edge strobe.
  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      edge_stb_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], bus.pulse};
      prev_q     <= sync_q[1];
      edge_stb_q <= sync_q[1] & ~prev_q;
    end
  end

  // Edge counter increment, holding once the overflow value is reached.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (edge_stb_q && (edge_cnt_q != CNT_SAT))
      edge_cnt_d = edge_cnt_q + 1'b1;
  end

  assign ovf_flag    = (edge_cnt_q == CNT_SAT);
  assign bin_clamped = clamp_cnt(edge_cnt_q);

  bin2bcd_seq #(
    .CNT_W (CNT_W)
  ) u_bin2bcd (
    .clk100    (clk100),
    .rst       (rst),
    .start     (start_q),
    .bin_i     (bin_clamped),
    .bcd_o     (bcd),
    .conv_done (conv_done)
  );

  // Measurement FSM with registered status outputs and readout latch.
  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      start_q    <= 1'b0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.meas_en) begin
            state_q    <= GATE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            gate_q     <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        GATE: begin
          edge_cnt_q <= edge_cnt_d;
          gate_cnt_q <= gate_cnt_q + 1'b1;
          if (gate_cnt_q == GATE_LAST) begin
            state_q <= CONV;
            gate_q  <= 1'b0;
            start_q <= 1'b1;
          end
        end
        CONV: begin
          if (conv_done) begin
            state_q  <= LATCH;
            digits_q <= bcd;
            ovf_q    <= ovf_flag;
            done_q   <= 1'b1;
          end
        end
        LATCH: begin
          if (bus.meas_en) begin
            state_q    <= GATE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            gate_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gate      = gate_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.fre_num_u = digits_q[0*BCD_W +: BCD_W];
  assign bus.fre_num_d = digits_q[1*BCD_W +: BCD_W];
  assign bus.fre_num_h = digits_q[2*BCD_W +: BCD_W];
  assign bus.fre_num_t = digits_q[3*BCD_W +: BCD_W];
  assign bus.fre_num_m = digits_q[4*BCD_W +: BCD_W];
  assign bus.fre_num_l = digits_q[5*BCD_W +: BCD_W];

endmodule
